// File: rtl/ef_uart_pkg.sv
// Shared UART types and constants: receiver states, parity encodings, data-size limits.
// No logic of its own; imported by the RX engine, its bus interface and the TX side.
// Backpressure: not applicable.
package ef_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_BRK_WAIT
    } rx_state_e;

    localparam logic [2:0] PAR_NONE   = 3'd0;
    localparam logic [2:0] PAR_ODD    = 3'd1;
    localparam logic [2:0] PAR_EVEN   = 3'd2;
    localparam logic [2:0] PAR_STICK0 = 3'd3;
    localparam logic [2:0] PAR_STICK1 = 3'd4;

    localparam int DEF_OVS = 16;
    localparam int DEF_MDW = 9;

    localparam logic [3:0] DS_MIN = 4'd5;

    function automatic logic [3:0] clamp_ds(input logic [3:0] ds, input logic [3:0] ds_max);
        if (ds < DS_MIN)
            return DS_MIN;
        else if (ds > ds_max)
            return ds_max;
        else
            return ds;
    endfunction

    function automatic logic [2:0] norm_parity(input logic [2:0] p);
        return (p > PAR_STICK1) ? PAR_NONE : p;
    endfunction

endpackage

// File: rtl/ef_uart_rx_cfg_if.sv
// Holding-register handshake between the RX engine and its bus wrapper or RX FIFO.
// Latency: rd clears valid on the following clock edge.
// Backpressure: while valid is high and rd is low, newly completed frames are dropped.
interface ef_uart_rx_cfg_if #(
    parameter int MDW = ef_uart_pkg::DEF_MDW
) ();
    logic           rd;
    logic [MDW-1:0] data;
    logic           valid;
    logic           parity_err;
    logic           frame_err;

    modport master (output rd, input data, valid, parity_err, frame_err);
    modport slave  (input rd, output data, valid, parity_err, frame_err);
endinterface

// File: rtl/ef_uart_tick_gen.sv
// Baud prescaler: emits one sample tick every prescale+1 clocks.
// Latency: tick is combinational from the counter; the counter restarts from 0 when en rises.
// Backpressure: none, free-running.
module ef_uart_tick_gen #(
    parameter int PSW = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [PSW-1:0] prescale,
    output logic           tick
);
    logic [PSW-1:0] cnt_q;

    // >= rather than == so lowering prescale on the fly cannot strand the counter
    assign tick = en && (cnt_q >= prescale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (!en || cnt_q >= prescale)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + PSW'(1);
    end
endmodule

// File: rtl/ef_uart_rx_cfg.sv
// Runtime-configurable UART receiver: 5..MDW data bits, 5 parity modes, 1/2 stop bits, break, timeout.
// Latency: a frame lands in the holding register at its last stop-bit sample point.
// Backpressure: single-entry holding register; a completed frame arriving while it is full (and not read) is dropped with an overrun pulse.
module ef_uart_rx_cfg
    import ef_uart_pkg::*;
#(
    parameter int MDW = DEF_MDW,
    parameter int OVS = DEF_OVS,
    parameter int PSW = 16,
    parameter int TOW = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [PSW-1:0] prescale,
    input  logic [3:0]     data_size,
    input  logic [2:0]     parity_type,
    input  logic           stop_bits,
    input  logic [TOW-1:0] timeout_bits,
    input  logic           rx,
    ef_uart_rx_cfg_if.slave hold,
    output logic           break_det,
    output logic           overrun,
    output logic           timeout,
    output logic           busy
);
    localparam int              BCW        = $clog2(OVS);
    localparam logic [BCW-1:0]  SMP_A      = BCW'(OVS/2 - 1);
    localparam logic [BCW-1:0]  SMP_B      = BCW'(OVS/2);
    localparam logic [BCW-1:0]  SMP_C      = BCW'(OVS/2 + 1);
    localparam logic [BCW-1:0]  BIT_LAST   = BCW'(OVS - 1);
    // Ticks already spent in the synchroniser and edge detect when the start edge is seen
    localparam logic [BCW-1:0]  BIT_PRESET = BCW'(3);
    localparam logic [3:0]      DS_MAX     = 4'(MDW);

    logic           rx_s1, rx_s2, rx_q;
    logic           tick;
    rx_state_e      state_q, state_d;
    logic [BCW-1:0] bit_cnt;
    logic           smp_a, smp_b;
    logic [3:0]     ds_q, dcnt;
    logic [2:0]     par_q;
    logic           sb_q;
    logic [MDW-1:0] shreg;
    logic           par_acc, perr_q, ferr_q, zero_q;
    logic [TOW-1:0] idle_cnt;
    logic [MDW-1:0] data_q;
    logic           valid_q, pe_q, fe_q;
    logic           start_edge, samp_pt, maj, par_exp, done, brk_hit;

    ef_uart_tick_gen #(.PSW(PSW)) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .prescale (prescale),
        .tick     (tick)
    );

    assign start_edge = en && (state_q == ST_IDLE) && rx_q && !rx_s2;
    assign samp_pt    = tick && (bit_cnt == SMP_C);
    assign maj        = (smp_a & smp_b) | (smp_a & rx_s2) | (smp_b & rx_s2);

    always_comb begin
        par_exp = 1'b0;
        case (par_q)
            PAR_ODD:    par_exp = ~par_acc;
            PAR_EVEN:   par_exp = par_acc;
            PAR_STICK0: par_exp = 1'b0;
            PAR_STICK1: par_exp = 1'b1;
            default:    par_exp = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        brk_hit = 1'b0;
        case (state_q)
            ST_IDLE:     if (start_edge) state_d = ST_START;
            ST_START:    if (samp_pt) state_d = maj ? ST_IDLE : ST_DATA;
            ST_DATA:     if (samp_pt && dcnt == ds_q - 4'd1)
                             state_d = (par_q != PAR_NONE) ? ST_PARITY : ST_STOP1;
            ST_PARITY:   if (samp_pt) state_d = ST_STOP1;
            ST_STOP1:    if (samp_pt) begin
                             if (!maj && zero_q) begin
                                 brk_hit = 1'b1;
                                 state_d = ST_BRK_WAIT;
                             end else if (sb_q) begin
                                 state_d = ST_STOP2;
                             end else begin
                                 done    = 1'b1;
                                 state_d = ST_IDLE;
                             end
                         end
            ST_STOP2:    if (samp_pt) begin
                             done    = 1'b1;
                             state_d = ST_IDLE;
                         end
            ST_BRK_WAIT: if (rx_s2) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        if (!en)
            state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_q    <= 1'b1;
            bit_cnt <= '0;
            smp_a   <= 1'b1;
            smp_b   <= 1'b1;
            ds_q    <= 4'd8;
            par_q   <= PAR_NONE;
            sb_q    <= 1'b0;
            shreg   <= '0;
            dcnt    <= '0;
            par_acc <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_q  <= rx_s2;

            if (!en)
                bit_cnt <= '0;
            else if (start_edge)
                bit_cnt <= BIT_PRESET;
            else if (done)
                bit_cnt <= '0;
            else if (tick)
                bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BCW'(1);

            if (tick && bit_cnt == SMP_A) smp_a <= rx_s2;
            if (tick && bit_cnt == SMP_B) smp_b <= rx_s2;

            if (start_edge) begin
                ds_q    <= clamp_ds(data_size, DS_MAX);
                par_q   <= norm_parity(parity_type);
                sb_q    <= stop_bits;
                shreg   <= '0;
                dcnt    <= '0;
                par_acc <= 1'b0;
                perr_q  <= 1'b0;
                ferr_q  <= 1'b0;
                zero_q  <= 1'b1;
            end

            if (samp_pt) begin
                case (state_q)
                    ST_DATA: begin
                        for (int i = 0; i < MDW; i++)
                            if (dcnt == 4'(i)) shreg[i] <= maj;
                        dcnt    <= dcnt + 4'd1;
                        par_acc <= par_acc ^ maj;
                        if (maj) zero_q <= 1'b0;
                    end
                    ST_PARITY: begin
                        perr_q <= (maj != par_exp);
                        if (maj) zero_q <= 1'b0;
                    end
                    ST_STOP1: ferr_q <= !maj;
                    default: ;
                endcase
            end
        end
    end

    // Holding register, event pulses and idle-timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            overrun   <= 1'b0;
            break_det <= 1'b0;
            timeout   <= 1'b0;
            idle_cnt  <= '0;
        end else begin
            overrun   <= 1'b0;
            break_det <= brk_hit;
            timeout   <= 1'b0;

            if (done) begin
                if (!valid_q || hold.rd) begin
                    data_q  <= shreg;
                    pe_q    <= perr_q;
                    fe_q    <= ferr_q | ~maj;
                    valid_q <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (hold.rd && valid_q) begin
                valid_q <= 1'b0;
            end

            // Saturating count means the pulse fires once until the counter is cleared
            if (!en || start_edge || hold.rd || !valid_q) begin
                idle_cnt <= '0;
            end else if (state_q == ST_IDLE && tick && bit_cnt == BIT_LAST && idle_cnt != '1) begin
                idle_cnt <= idle_cnt + TOW'(1);
                timeout  <= (timeout_bits != '0) && (idle_cnt + TOW'(1) == timeout_bits);
            end
        end
    end

    assign hold.data       = data_q;
    assign hold.valid      = valid_q;
    assign hold.parity_err = pe_q;
    assign hold.frame_err  = fe_q;
    assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ef_uart_rx_cfg.sv
// Directed bench for ef_uart_rx_cfg: prescale=0, OVS=16, so one bit lasts 16 clocks.
module tb_ef_uart_rx_cfg;
    import ef_uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] prescale = '0;
    logic [3:0]  data_size = 4'd8;
    logic [2:0]  parity_type = PAR_NONE;
    logic        stop_bits = 1'b0;
    logic [5:0]  timeout_bits = '0;
    logic        rx = 1'b1;
    logic        break_det, overrun, timeout, busy;

    ef_uart_rx_cfg_if #(.MDW(9)) bus ();

    ef_uart_rx_cfg #(.MDW(9), .OVS(16), .PSW(16), .TOW(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .prescale     (prescale),
        .data_size    (data_size),
        .parity_type  (parity_type),
        .stop_bits    (stop_bits),
        .timeout_bits (timeout_bits),
        .rx           (rx),
        .hold         (bus),
        .break_det    (break_det),
        .overrun      (overrun),
        .timeout      (timeout),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, n_brk = 0, n_ovr = 0, n_to = 0, ovr_cyc = 0, to_cyc = 0;
    int lat, b0, o0, t0, n;

    always @(negedge clk) begin
        cyc++;
        if (break_det) n_brk++;
        if (overrun) begin n_ovr++; ovr_cyc = cyc; end
        if (timeout) begin n_to++;  to_cyc  = cyc; end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic clks(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // pbit < 0 means no parity bit; s1 is the level driven in the first stop bit
    task automatic send(input logic [8:0] d, input int ds, input int pbit, input logic s1, input int nstop);
        rx = 1'b0;
        clks(16);
        for (int i = 0; i < ds; i++) begin
            rx = d[i];
            clks(16);
        end
        if (pbit >= 0) begin
            rx = pbit[0];
            clks(16);
        end
        rx = s1;
        clks(16);
        if (nstop == 2) begin
            rx = 1'b1;
            clks(16);
        end
        rx = 1'b1;
    endtask

    task automatic pop();
        bus.rd = 1'b1;
        clks(1);
        bus.rd = 1'b0;
    endtask

    initial begin
        bus.rd = 1'b0;
        clks(3);
        chk("rst_valid", bus.valid, 0);
        chk("rst_data",  bus.data, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_pulses", {break_det, overrun, timeout, bus.parity_err, bus.frame_err}, 0);
        rst_n = 1'b1;
        en    = 1'b1;
        clks(20);

        // 8N1 0xA5, latency measured from the line edge (2 synchroniser clocks + 152)
        fork
            send(9'h0A5, 8, -1, 1'b1, 1);
            begin
                lat = 0;
                while (!bus.valid && lat < 200) begin clks(1); lat++; end
            end
        join
        chk("t1_lat_le_154", lat <= 154, 1);
        chk("t1_data", bus.data, 9'h0A5);
        chk("t1_errs", {bus.parity_err, bus.frame_err}, 0);
        pop();
        chk("t1_rd_clears", bus.valid, 0);

        // 7E2 0x35: four ones, so even parity bit is 0
        clks(16);
        data_size = 4'd7; parity_type = PAR_EVEN; stop_bits = 1'b1;
        send(9'h035, 7, 1, 1'b1, 2);
        chk("t2_data", bus.data, 9'h035);
        chk("t2_perr", bus.parity_err, 1);
        chk("t2_ferr", bus.frame_err, 0);
        pop();
        clks(16);
        send(9'h035, 7, 0, 1'b1, 2);
        chk("t2_ok_perr", bus.parity_err, 0);
        chk("t2_ok_vld", bus.valid, 1);
        pop();

        // 9-bit odd: 0x1FF and 0x100 both carry parity bit 0
        clks(16);
        data_size = 4'd9; parity_type = PAR_ODD; stop_bits = 1'b0;
        send(9'h1FF, 9, 0, 1'b1, 1);
        chk("t3_data_a", bus.data, 9'h1FF);
        chk("t3_errs_a", {bus.parity_err, bus.frame_err}, 0);
        pop();
        clks(16);
        b0 = n_brk;
        send(9'h100, 9, 0, 1'b0, 1);
        clks(16);
        chk("t3_data_b", bus.data, 9'h100);
        chk("t3_ferr_b", bus.frame_err, 1);
        chk("t3_perr_b", bus.parity_err, 0);
        chk("t3_no_brk", n_brk - b0, 0);
        pop();

        // 3-clock glitch is rejected as a false start
        clks(16);
        data_size = 4'd8; parity_type = PAR_NONE;
        rx = 1'b0;
        clks(3);
        rx = 1'b1;
        chk("t4_busy_hi", busy, 1);
        clks(13);
        chk("t4_busy_lo", busy, 0);
        chk("t4_no_vld", bus.valid, 0);
        clks(16);
        send(9'h03C, 8, -1, 1'b1, 1);
        chk("t4_data", bus.data, 9'h03C);
        chk("t4_vld", bus.valid, 1);
        pop();

        // Break: line low for 12 bit times
        clks(16);
        b0 = n_brk;
        rx = 1'b0;
        clks(192);
        chk("t5_brk_once", n_brk - b0, 1);
        chk("t5_no_vld", bus.valid, 0);
        chk("t5_busy", busy, 1);
        rx = 1'b1;
        clks(6);
        chk("t5_idle", busy, 0);
        clks(16);
        send(9'h055, 8, -1, 1'b1, 1);
        chk("t5_data", bus.data, 9'h055);
        pop();

        // Overrun and idle timeout
        clks(16);
        timeout_bits = 6'd4;
        o0 = n_ovr; t0 = n_to;
        send(9'h011, 8, -1, 1'b1, 1);
        send(9'h022, 8, -1, 1'b1, 1);
        chk("t6_ovr", n_ovr - o0, 1);
        chk("t6_data", bus.data, 9'h011);
        n = 0;
        while (n_to == t0 && n < 200) begin clks(1); n++; end
        chk("t6_to_seen", n_to - t0, 1);
        chk("t6_to_delay", to_cyc - ovr_cyc, 64);
        clks(200);
        chk("t6_to_once", n_to - t0, 1);
        pop();
        chk("t6_rd_clears", bus.valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule

// File: doc/ef_uart_rx_cfg.md
Name: ef_uart_rx_cfg

Overview:
Parametrised, runtime-configurable UART receive engine. It is the next-generation RX core behind the Wishbone/APB UART wrappers. It supports 5..MDW data bits, five parity modes, 1/2 stop bits, 3-sample majority voting, break detection, overrun and an idle-timeout event. It feeds a single-entry holding register that the bus wrapper (or an RX FIFO) drains through a valid/rd handshake.

Parameters:
MDW, 9, maximum data width in bits; supported range 5..9
OVS, 16, oversampling ticks per bit; even value, minimum 8
PSW, 16, prescaler width
TOW, 6, width of the timeout_bits configuration field

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  receiver enable
prescale  in  PSW  sample tick every prescale+1 clocks
data_size  in  4  data bits per frame, 5..MDW; values outside this range are clamped to it
parity_type  in  3  0 none, 1 odd, 2 even, 3 stick-0, 4 stick-1; values 5..7 are treated as none
stop_bits  in  1  0 one stop bit, 1 two stop bits
timeout_bits  in  TOW  idle bit-times before a timeout pulse; 0 disables timeout
rx  in  1  asynchronous serial input
rd  in  1  pop the holding register
data  out  MDW  received word, right-aligned, upper bits zero
valid  out  1  holding register full
parity_err  out  1  parity error of the held word
frame_err  out  1  stop-bit error of the held word
break_det  out  1  one-cycle pulse on break
overrun  out  1  one-cycle pulse when a completed frame is dropped
timeout  out  1  one-cycle pulse on idle timeout
busy  out  1  state is not IDLE

Behaviour:
- Reset: all outputs 0. rx synchroniser flops reset to 1. Tick counter 0. State IDLE.
- rx passes through a 2-flop synchroniser; all references to rx below mean the synchronised value.
- Tick generator: counts 0..prescale and emits tick when count==prescale. prescale=0 gives a tick every clock. Counter is held at 0 while en=0.
- Bit timer: counts ticks 0..OVS-1 within each bit. Sample = majority of rx at ticks OVS/2-1, OVS/2, OVS/2+1. The bit timer advances at tick OVS-1.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT.
- IDLE -> START: on a falling edge of rx. data_size, parity_type and stop_bits are latched at this point; changes mid-frame have no effect until the next frame.
- START, at the majority sample: 1 is a false start, return to IDLE; 0 goes to DATA.
- DATA: shifts in latched data_size bits, LSB first. Then PARITY if parity enabled, else STOP1.
- PARITY: odd/even are computed over the data bits only; stick modes compare the sample against the fixed value.
- STOP1: at the majority sample, a 0 sets frame_err for this frame. If stop_bits=1, go to STOP2; otherwise the frame completes. STOP2 is checked the same way.
- Frame completes at the stop-bit sample point, not at the end of the bit, so the next start edge is never missed.
- Break: data all 0, parity sample 0 (if enabled) and STOP1 sample 0. Then break_det pulses once, nothing is written to the holding register, and state goes to BRK_WAIT. BRK_WAIT returns to IDLE when rx=1.
- Holding register:
  - On completion with valid=0: load data, parity_err, frame_err and set valid.
  - rd with valid=1 clears valid on the next edge. rd with valid=0 is ignored.
  - Completion with valid=1 and no rd in the same cycle: the new frame is dropped, old contents are kept, overrun pulses.
  - Completion and rd in the same cycle: the new frame is loaded, valid stays 1, no overrun.
- Timeout:
  - An idle counter counts bit periods while state==IDLE and valid=1.
  - It clears on a start edge, on rd, or when valid=0.
  - At count==timeout_bits (nonzero), timeout pulses once; it cannot fire again until the counter is cleared.
- en=0: synchronously forces state to IDLE and clears the bit, tick and idle counters. The holding register and valid are retained; rd still works.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is lost.

Decomposition:
- Package ef_uart_pkg holds:
  - state enum
  - parity encodings (PAR_NONE, PAR_ODD, PAR_EVEN, PAR_STICK0, PAR_STICK1)
  - default constants: OVS=16, MDW=9
  - data_size clamp limits
- One sub-module: ef_uart_tick_gen (prescaler and tick), shareable with the TX engine.

Test Plan:
All cases use prescale=0, OVS=16, so one bit is 16 clocks.
1. 8N1, send 0xA5 -> data=0x0A5, valid=1 within 152 clocks of the start edge, parity_err=0, frame_err=0. Assert rd -> valid=0 next cycle.
2. 7E2, send 0x35 with the parity bit inverted -> data=0x035, parity_err=1, frame_err=0. Repeat with a correct parity bit -> parity_err=0.
3. 9-bit odd parity, send 0x1FF, then 0x100 with STOP1 driven 0 -> first frame data=0x1FF with no errors. Read it. Second frame data=0x100, frame_err=1, break_det=0.
4. Glitch: rx low for 3 clocks -> no valid, busy returns to 0 within 16 clocks. A following valid 0x3C is received correctly.
5. Break in 8N1: rx held low for 12 bit times -> exactly one break_det pulse, valid stays 0, busy=1 until rx rises. A frame 0x55 afterwards is received.
6. Two frames 0x11 then 0x22 with no rd, and timeout_bits=4 -> one overrun pulse and data remains 0x011. One timeout pulse 64 clocks after the second frame's stop sample. No second pulse before rd.
